// File: rtl/ps2_letter_decoder.sv
// PS/2 keyboard receiver (scan code set 2) that turns letter make-codes into
// 1..26 character codes and flags Enter presses and malformed frames.
module ps2_letter_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [4:0] letter,
    output logic       letter_valid,
    output logic       enter_valid,
    output logic       frame_error,
    output logic [7:0] last_code
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_level, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          ext, brk;
    logic [7:0]    held;
    logic [4:0]    letter_code;

    // The filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            filt_level <= 1'b1;
            filt_prev  <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_s1    <= ps2_clk;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_dat;
            dat_s2    <= dat_s1;
            filt_prev <= filt_level;
            if (clk_s2 == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_MAX) begin
                filt_level <= clk_s2;
                filt_cnt   <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt_level;

    always_comb begin
        letter_code = 5'd0;
        case (shreg)
            8'h1C: letter_code = 5'd1;
            8'h32: letter_code = 5'd2;
            8'h21: letter_code = 5'd3;
            8'h23: letter_code = 5'd4;
            8'h24: letter_code = 5'd5;
            8'h2B: letter_code = 5'd6;
            8'h34: letter_code = 5'd7;
            8'h33: letter_code = 5'd8;
            8'h43: letter_code = 5'd9;
            8'h3B: letter_code = 5'd10;
            8'h42: letter_code = 5'd11;
            8'h4B: letter_code = 5'd12;
            8'h3A: letter_code = 5'd13;
            8'h31: letter_code = 5'd14;
            8'h44: letter_code = 5'd15;
            8'h4D: letter_code = 5'd16;
            8'h15: letter_code = 5'd17;
            8'h2D: letter_code = 5'd18;
            8'h1B: letter_code = 5'd19;
            8'h2C: letter_code = 5'd20;
            8'h3C: letter_code = 5'd21;
            8'h2A: letter_code = 5'd22;
            8'h1D: letter_code = 5'd23;
            8'h22: letter_code = 5'd24;
            8'h35: letter_code = 5'd25;
            8'h1A: letter_code = 5'd26;
            default: letter_code = 5'd0;
        endcase
    end

    // Frame receiver and byte decoder share one block so a good byte is
    // classified in the same cycle its stop bit is seen.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            tmo_cnt      <= '0;
            ext          <= 1'b0;
            brk          <= 1'b0;
            held         <= '0;
            letter       <= '0;
            letter_valid <= 1'b0;
            enter_valid  <= 1'b0;
            frame_error  <= 1'b0;
            last_code    <= '0;
        end else begin
            letter_valid <= 1'b0;
            enter_valid  <= 1'b0;
            frame_error  <= 1'b0;

            if (state == IDLE || fall) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (state != IDLE && !fall && tmo_cnt == TMO_MAX) begin
                state       <= IDLE;
                frame_error <= 1'b1;
                tmo_cnt     <= '0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (dat_s2 && ((^shreg) ^ par_bit)) begin
                            last_code <= shreg;
                            if (shreg == 8'hE0) begin
                                ext <= 1'b1;
                            end else if (shreg == 8'hF0) begin
                                brk <= 1'b1;
                            end else begin
                                ext <= 1'b0;
                                brk <= 1'b0;
                                if (brk) begin
                                    if (shreg == held) begin
                                        held <= '0;
                                    end
                                end else if (!ext && shreg != held) begin
                                    held <= shreg;
                                    if (letter_code != 5'd0) begin
                                        letter       <= letter_code;
                                        letter_valid <= 1'b1;
                                    end else if (shreg == 8'h5A) begin
                                        enter_valid <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
